// File: rtl/flash_pkg.sv
// Shared types and constants for the bound-flasher step scheduler,
// its state machine and its LED counter.
package flash_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_e;

   localparam int unsigned DEB_CYC_DEF = 4;
   localparam int unsigned CNT_W       = 5;
   localparam int unsigned DEB_W       = 8;

endpackage

// File: rtl/flick_debounce.sv
// Two-flop synchroniser plus stable-sample debounce for the flick pushbutton.
module flick_debounce
   import flash_pkg::*;
#(
   parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic flick_raw,
   output logic flick_clean
);

   logic             sync1_q;
   logic             sync2_q;
   logic             clean_q;
   logic             clean_d;
   logic [DEB_W-1:0] cnt_q;
   logic [DEB_W-1:0] cnt_d;

   // Count consecutive samples that disagree with the clean level.
   always_comb begin
      clean_d = clean_q;
      cnt_d   = '0;
      if (sync2_q != clean_q) begin
         if (cnt_q + DEB_W'(1) == DEB_W'(DEB_CYC)) begin
            clean_d = sync2_q;
         end else begin
            cnt_d = cnt_q + DEB_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         clean_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= flick_raw;
         sync2_q <= sync1_q;
         clean_q <= clean_d;
         cnt_q   <= cnt_d;
      end
   end

   assign flick_clean = clean_q;

endmodule

// File: rtl/flash_step_ctrl.sv
// Step scheduler: debounced flick, programmable step tick, pause hold.
// Optional FLASH_SINGLE_STEP_EN adds step_req for single steps while paused.
module flash_step_ctrl
   import flash_pkg::*;
#(
   parameter int unsigned DIV_W   = 16,
   parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flick_raw,
   input  logic             pause,
`ifdef FLASH_SINGLE_STEP_EN
   input  logic             step_req,
`endif
   input  logic [DIV_W-1:0] div_cfg,
   input  logic             fsm_enable,
   input  logic             fsm_upcount,
   output logic             flick_clean,
   output logic             step_tick,
   output logic             cnt_en,
   output logic             cnt_up,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [DIV_W-1:0] n_q, n_d;
   logic             tick_q, tick_d;
   logic             busy_q, busy_d;
   logic             wrap_c;
   logic             single_c;

   flick_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk        (clk),
      .reset_n    (reset_n),
      .flick_raw  (flick_raw),
      .flick_clean(flick_clean)
   );

`ifdef FLASH_SINGLE_STEP_EN
   logic step_req_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) step_req_q <= 1'b0;
      else          step_req_q <= step_req;
   end

   assign single_c = step_req & ~step_req_q;
`else
   assign single_c = 1'b0;
`endif

   assign wrap_c = (div_cnt_q == n_q - DIV_W'(1));

   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      n_d       = n_q;
      tick_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            tick_d    = 1'b1;
            div_cnt_d = '0;
            if (fsm_enable) begin
               state_d = ST_RUN;
               n_d     = (div_cfg == '0) ? DIV_W'(1) : div_cfg;
            end
         end
         ST_RUN: begin
            if (tick_q && !fsm_enable) begin
               state_d   = ST_IDLE;
               div_cnt_d = '0;
               tick_d    = 1'b1;
            end else if (pause) begin
               state_d = ST_PAUSE;
            end else if (wrap_c) begin
               tick_d    = 1'b1;
               div_cnt_d = '0;
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end
         ST_PAUSE: begin
            // Releasing pause counts this cycle, so a hold of P cycles delays by P.
            if (!pause) begin
               state_d = ST_RUN;
               if (wrap_c) begin
                  tick_d    = 1'b1;
                  div_cnt_d = '0;
               end else begin
                  div_cnt_d = div_cnt_q + DIV_W'(1);
               end
            end else begin
               tick_d = single_c;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         div_cnt_q <= '0;
         n_q       <= '0;
         tick_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         n_q       <= n_d;
         tick_q    <= tick_d;
         busy_q    <= busy_d;
      end
   end

   assign step_tick = tick_q;
   assign busy      = busy_q;
   assign cnt_en    = tick_q & fsm_enable;
   assign cnt_up    = cnt_en & fsm_upcount;

endmodule

// File: tb/tb_flash_step_ctrl.sv
// Self-checking bench for flash_step_ctrl: window/modulo model plus directed checks.
module tb_flash_step_ctrl;
   import flash_pkg::*;

   localparam int unsigned DW  = 16;
   localparam int unsigned DEB = DEB_CYC_DEF;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          flick_raw;
   logic          pause;
   logic [DW-1:0] div_cfg;
   logic          fsm_enable;
   logic          fsm_upcount;
   logic          flick_clean;
   logic          step_tick;
   logic          cnt_en;
   logic          cnt_up;
   logic          busy;
`ifdef FLASH_SINGLE_STEP_EN
   logic          step_req;
`endif

   int checks = 0;
   int passes = 0;

   flash_step_ctrl #(.DIV_W(DW), .DEB_CYC(DEB)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .flick_raw  (flick_raw),
      .pause      (pause),
`ifdef FLASH_SINGLE_STEP_EN
      .step_req   (step_req),
`endif
      .div_cfg    (div_cfg),
      .fsm_enable (fsm_enable),
      .fsm_upcount(fsm_upcount),
      .flick_clean(flick_clean),
      .step_tick  (step_tick),
      .cnt_en     (cnt_en),
      .cnt_up     (cnt_up),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
   endtask

   // Model: flick flips after DEB consecutive delayed samples differ from it;
   // in RUN a tick falls on every un-paused cycle whose ordinal is a multiple of N.
   int  m_mode;          // 0 idle, 1 run, 2 pause
   int  m_k;
   int  m_n;
   bit  m_tick;
   bit  m_clean;
   bit  m_sreq_prev;
   bit  rq[$];
   bit  wq[$];

   always @(posedge clk or negedge reset_n) begin : model
      bit syncv;
      bit allmis;
      bit prev_tick;
      if (!reset_n) begin
         m_mode = 0; m_k = 0; m_n = 1; m_tick = 0; m_clean = 0; m_sreq_prev = 0;
         rq.delete(); wq.delete();
      end else begin
         syncv = (rq.size() >= 2) ? rq[rq.size()-2] : 1'b0;
         wq.push_back(syncv);
         if (wq.size() > DEB) void'(wq.pop_front());
         allmis = (wq.size() == DEB);
         foreach (wq[i]) if (wq[i] == m_clean) allmis = 0;
         if (allmis) m_clean = !m_clean;
         rq.push_back(flick_raw);
         if (rq.size() > 2) void'(rq.pop_front());

         prev_tick = m_tick;
         m_tick = 0;
         case (m_mode)
            0: begin
               m_tick = 1;
               if (fsm_enable) begin
                  m_mode = 1; m_k = 0;
                  m_n = (div_cfg == 0) ? 1 : int'(div_cfg);
               end
            end
            1: begin
               if (prev_tick && !fsm_enable) begin m_mode = 0; m_tick = 1; end
               else if (pause) m_mode = 2;
               else begin m_k++; m_tick = (m_k % m_n == 0); end
            end
            default: begin
               if (!pause) begin m_mode = 1; m_k++; m_tick = (m_k % m_n == 0); end
`ifdef FLASH_SINGLE_STEP_EN
               else m_tick = step_req && !m_sreq_prev;
`endif
            end
         endcase
`ifdef FLASH_SINGLE_STEP_EN
         m_sreq_prev = step_req;
`endif
      end
   end

   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         chk("cyc_flick_clean", int'(flick_clean), int'(m_clean));
         chk("cyc_step_tick",   int'(step_tick),   int'(m_tick));
         chk("cyc_busy",        int'(busy),        int'(m_mode != 0));
         chk("cyc_cnt_en",      int'(cnt_en),      int'(m_tick && fsm_enable));
         chk("cyc_cnt_up",      int'(cnt_up),      int'(m_tick && fsm_enable && fsm_upcount));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin cyc(); n++; end while (!step_tick && n < 40);
   endtask

   task automatic wait_clean(input bit v, output int n);
      n = 0;
      do begin cyc(); n++; end while (flick_clean != v && n < 40);
   endtask

   // Pause 2 cycles into a period for 7 cycles; optionally pulse step_req twice.
   task automatic pause_run(input bit with_steps, output int nticks, output int after);
      bit pat [7];
      pat = '{0, 1, 0, 0, 1, 0, 0};
      nticks = 0;
      wait_tick(after);
      cyc(); cyc();
      pause = 1'b1;
`ifdef FLASH_SINGLE_STEP_EN
      step_req = with_steps & pat[0];
`endif
      for (int i = 0; i < 7; i++) begin
         cyc();
         if (step_tick) nticks++;
`ifdef FLASH_SINGLE_STEP_EN
         step_req = (i < 6) ? (with_steps & pat[i+1]) : 1'b0;
`else
         if (with_steps && pat[i]) nticks = nticks + 0;
`endif
      end
      pause = 1'b0;
      wait_tick(after);
   endtask

   initial begin : stim
      int n, t, a;
      bit glitch_seen;
      reset_n = 0; flick_raw = 0; pause = 0; div_cfg = '0;
      fsm_enable = 0; fsm_upcount = 0;
`ifdef FLASH_SINGLE_STEP_EN
      step_req = 0;
`endif
      #1;
      chk("rst_flick_clean", int'(flick_clean), 0);
      chk("rst_step_tick",   int'(step_tick),   0);
      chk("rst_busy",        int'(busy),        0);
      chk("rst_cnt_en",      int'(cnt_en),      0);
      cyc(); cyc();
      reset_n = 1;

      // Flick rise latency, glitch rejection, fall latency
      flick_raw = 1;
      wait_clean(1'b1, n);
      chk("flick_rise_lat", n, 6);
      flick_raw = 0;
      cyc(); cyc(); cyc();
      flick_raw = 1;
      glitch_seen = 0;
      repeat (10) begin cyc(); if (!flick_clean) glitch_seen = 1; end
      chk("flick_glitch", int'(glitch_seen), 0);
      flick_raw = 0;
      wait_clean(1'b0, n);
      chk("flick_fall_lat", n, 6);
      flick_raw = 1;

      // RUN with N = 5; div_cfg changes mid-RUN are ignored
      chk("idle_tick", int'(step_tick), 1);
      div_cfg = 16'd5; fsm_enable = 1; fsm_upcount = 1;
      cyc();
      chk("run_busy", int'(busy), 1);
      chk("run_entry_tick", int'(step_tick), 1);
      div_cfg = 16'd2;
      wait_tick(n);
      chk("run_period1", n, 5);
      wait_tick(n);
      chk("run_period2", n, 5);
      chk("run_cnt_en", int'(cnt_en), 1);
      chk("run_cnt_up", int'(cnt_up), 1);
      fsm_upcount = 0;
      wait_tick(n);
      chk("run_period3", n, 5);
      chk("run_cnt_dn", int'(cnt_up), 0);

      pause_run(1'b0, t, a);
      chk("pause_ticks", t, 0);
      chk("pause_resume", a, 3);
`ifdef FLASH_SINGLE_STEP_EN
      pause_run(1'b1, t, a);
      chk("single_ticks", t, 2);
      chk("single_resume", a, 3);
`endif

      // Drop fsm_enable across a tick: back to IDLE
      wait_tick(n);
      repeat (4) cyc();
      fsm_enable = 0;
      cyc();
      chk("exit_tick", int'(step_tick), 1);
      chk("exit_busy_hold", int'(busy), 1);
      cyc();
      chk("exit_busy", int'(busy), 0);
      n = 0;
      repeat (4) begin cyc(); if (step_tick) n++; end
      chk("exit_idle_ticks", n, 4);

      // div_cfg = 0 behaves as N = 1
      div_cfg = '0; fsm_enable = 1;
      n = 0;
      repeat (6) begin cyc(); if (step_tick && busy) n++; end
      chk("n1_ticks", n, 6);

      // Asynchronous reset mid-RUN
      chk("pre_rst_clean", int'(flick_clean), 1);
      reset_n = 0;
      #1;
      chk("arst_flick_clean", int'(flick_clean), 0);
      chk("arst_step_tick",   int'(step_tick),   0);
      chk("arst_busy",        int'(busy),        0);
      chk("arst_cnt_en",      int'(cnt_en),      0);
      chk("arst_cnt_up",      int'(cnt_up),      0);
      cyc(); cyc();
      reset_n = 1;
      repeat (4) cyc();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passes, checks);
      $fatal(1);
   end

endmodule

// File: doc/flash_step_ctrl.md
Name: flash_step_ctrl

Overview:
Step scheduler between the bound-flasher state machine and its up/down LED counter.
- Conditions the raw flick pushbutton: synchroniser plus debounce.
- Generates a programmable-rate step tick that clock-enables both the state machine and the counter.
- Supports a pause hold.
- Gates the state machine's enable/upcount into counter controls, so the LED sweep advances at a human-visible rate.

Parameters:
DIV_W, 16, width of the step divider and of div_cfg.
DEB_CYC, 4, consecutive stable synchronised samples required before flick_clean changes; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
flick_raw  input  1  asynchronous pushbutton level.
pause  input  1  synchronous level; freezes stepping while high in RUN.
div_cfg  input  DIV_W  clocks per step; latched on IDLE->RUN; 0 treated as 1.
fsm_enable  input  1  enable output of the flasher state machine.
fsm_upcount  input  1  upcount output of the flasher state machine.
flick_clean  output  1  debounced flick level to the state machine.
step_tick  output  1  one-cycle clock enable for the state machine and counter.
cnt_en  output  1  counter enable = step_tick AND fsm_enable (combinational).
cnt_up  output  1  counter direction = fsm_upcount when cnt_en, else 0 (combinational).
busy  output  1  high when the scheduler state is not IDLE.

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE; sync flops, flick_clean, debounce count, divider count and latched divider all 0; step_tick 0, busy 0. Reset mid-step aborts with no pending tick.
- Flick path: 2-FF synchroniser, then debounce.
  - Debounce count clears whenever the synchronised value equals flick_clean.
  - Otherwise it increments; on reaching DEB_CYC, flick_clean takes the synchronised value and the count clears.
  - Latency from a flick_raw edge to flick_clean: 2 + DEB_CYC cycles. Glitches shorter than DEB_CYC cycles are rejected.
- States (registered): IDLE, RUN, PAUSE.
- IDLE:
  - step_tick = 1 every cycle, so the state machine free-runs while waiting on flick.
  - Divider count held at 0; pause ignored.
  - Exit to RUN when fsm_enable = 1 is sampled. On that edge, latch N = max(div_cfg, 1).
- RUN:
  - Divider count runs 0..N-1. step_tick is registered high for the one cycle after the count reaches N-1; the count then wraps to 0.
  - Step period is exactly N cycles.
  - RUN->PAUSE when pause = 1 (checked before the tick decision; a tick due that cycle is suppressed).
  - RUN->IDLE when step_tick = 1 and fsm_enable = 0. This covers both the return to START and the flick-hold state.
- PAUSE:
  - step_tick = 0; divider count frozen.
  - PAUSE->RUN when pause = 0; counting resumes from the frozen value.
  - reset_n is the only other exit.
- Simultaneous events: pause and the tick point in the same cycle gives PAUSE, no tick. div_cfg changes during RUN have no effect until the next IDLE->RUN transition.
- cnt_en and cnt_up are never asserted unless step_tick is 1.

Optional Feature:
FLASH_SINGLE_STEP_EN:
- Defined: adds input step_req (synchronous, level). In PAUSE, a 0->1 edge on step_req produces exactly one step_tick on the next cycle; the divider count stays frozen.
- Undefined: the port is absent and PAUSE never ticks.

Decomposition:
- Shared package flash_pkg holds:
  - state encoding typedef (IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2);
  - DEB_CYC default;
  - the counter width constant (5) used by the state machine and counter.
- One natural sub-module: flick_debounce (synchroniser plus debounce, params DEB_CYC, output flick_clean).

Test Plan:
- Reset, then flick_raw high: flick_clean rises 6 cycles later (DEB_CYC = 4). A 3-cycle pulse produces no flick_clean change.
- div_cfg = 5, fsm_enable driven high: busy rises; step_tick pulses every 5 cycles; cnt_en coincides with step_tick; cnt_up follows fsm_upcount.
- div_cfg = 0: step_tick is high every cycle in RUN.
- pause held for 7 cycles, asserted 2 cycles into a period with div_cfg = 5: no tick while paused; the next tick comes 3 cycles after pause falls.
- fsm_enable low at a tick: state returns to IDLE, step_tick is continuous, busy = 0. reset_n pulsed low mid-RUN: all outputs are 0 immediately.
- With FLASH_SINGLE_STEP_EN defined, in PAUSE, two step_req pulses: exactly two single-cycle step_ticks and the divider count unchanged.
